// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and executor FSM encoding
package alu_pkg;

  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_SLL     = 4'b0010;
  localparam logic [3:0] ALU_ADD     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0100;
  localparam logic [3:0] ALU_SRL     = 4'b0101;
  localparam logic [3:0] ALU_INVALID = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } exec_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - one-bit-per-cycle logical shifter with down-counter
// shifted is the value after the shift happening this cycle; done marks the last shift.
module serial_shifter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   right,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic [DATA_WIDTH-1:0]  shifted,
  output logic                   done
);

  logic [DATA_WIDTH-1:0]  value_q;
  logic [SHAMT_WIDTH-1:0] count_q;
  logic                   right_q;

  assign shifted = right_q ? (value_q >> 1) : (value_q << 1);
  assign done    = (count_q == SHAMT_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
      count_q <= '0;
      right_q <= 1'b0;
    end else if (load) begin
      value_q <= data;
      count_q <= shamt;
      right_q <= right;
    end else if (count_q != '0) begin
      value_q <= shifted;
      count_q <= count_q - SHAMT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/alu_op_executor.sv
// rtl/alu_op_executor.sv - execute-stage ALU: single-cycle ADD/OR/SUB, serial SLL/SRL
module alu_op_executor
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [DATA_WIDTH-1:0]  result_o,
  output logic                   zero_o,
  output logic                   error_o,
  output logic                   res_valid_o,
  input  logic                   res_ready_i
);

  exec_state_e           state, state_next;
  logic                  accept, start_shift, shift_done;
  logic [DATA_WIDTH-1:0] alu_res, shift_res;
  logic                  op_err;

  assign accept      = valid_i && ready_o;
  assign start_shift = accept && is_shift_op(alu_operation_i) && (shamt_i != '0);

  serial_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SHAMT_WIDTH(SHAMT_WIDTH)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (start_shift),
    .right  (alu_operation_i == ALU_SRL),
    .data   (a_i),
    .shamt  (shamt_i),
    .shifted(shift_res),
    .done   (shift_done)
  );

  // Shifts by zero pass a_i straight through; the decoder default code is unsupported here.
  always_comb begin
    alu_res = '0;
    op_err  = 1'b0;
    case (alu_operation_i)
      ALU_ADD:          alu_res = a_i + b_i;
      ALU_OR:           alu_res = a_i | b_i;
      ALU_SUB:          alu_res = a_i - b_i;
      ALU_SLL, ALU_SRL: alu_res = a_i;
      default:          op_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = start_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (shift_done) state_next = ST_DONE;
      ST_DONE:  if (res_ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_o     = (state == ST_IDLE);
    res_valid_o = (state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_o <= '0;
      zero_o   <= 1'b1;
      error_o  <= 1'b0;
    end else if (accept && !start_shift) begin
      result_o <= alu_res;
      zero_o   <= (alu_res == '0);
      error_o  <= op_err;
    end else if (state == ST_SHIFT && shift_done) begin
      result_o <= shift_res;
      zero_o   <= (shift_res == '0);
      error_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_op_executor.sv
// tb/tb_alu_op_executor.sv - scoreboard bench for alu_op_executor
module tb_alu_op_executor;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  alu_operation;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        valid;
  logic        ready;
  logic [31:0] result;
  logic        zero, error, res_valid;
  logic        res_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  alu_op_executor #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_operation_i(alu_operation),
    .a_i            (a),
    .b_i            (b),
    .shamt_i        (shamt),
    .valid_i        (valid),
    .ready_o        (ready),
    .result_o       (result),
    .zero_o         (zero),
    .error_o        (error),
    .res_valid_o    (res_valid),
    .res_ready_i    (res_ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [4:0] sh);
    exp_t e;
    e.err = 1'b0;
    case (op)
      4'b0011: e.res = x + y;
      4'b0001: e.res = x | y;
      4'b0100: e.res = x - y;
      4'b0010: e.res = x << sh;
      4'b0101: e.res = x >> sh;
      default: begin e.res = 32'h0; e.err = 1'b1; end
    endcase
    e.zero = (e.res == 32'h0);
    return e;
  endfunction

  // Present a request, record its expected result, hold it until accepted.
  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] sh, output bit ok);
    int n = 0;
    alu_operation = op; a = x; b = y; shamt = sh; valid = 1'b1;
    sb.push_back(model(op, x, y, sh));
    while (!ready && n < 200) begin @(posedge clk); #1; n++; end
    ok = ready;
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  // Wait for a result (counting edges from the accepting one), sample it, then take it.
  task automatic take(output logic [31:0] r, output logic z, output logic e,
                      output int cyc, output bit ok);
    cyc = 1;
    while (!res_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
    ok = res_valid; r = result; z = zero; e = error;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 5;
    if (ready !== 1'b1)      begin bad++; $display("FAIL reset_ready got=%b want=1", ready); end
    if (res_valid !== 1'b0)  begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    if (result !== 32'h0)    begin bad++; $display("FAIL reset_result got=%h want=0", result); end
    if (zero !== 1'b1)       begin bad++; $display("FAIL reset_zero got=%b want=1", zero); end
    if (error !== 1'b0)      begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    reset = 1'b0;
  endtask

  task automatic test_ops(input string name, input logic [3:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r; logic z, e; int cyc; bit ok_s, ok_t; exp_t ex; int lat;
    lat = ((op == 4'b0010 || op == 4'b0101) && sh != 0) ? sh + 1 : 1;
    send(op, x, y, sh, ok_s);
    take(r, z, e, cyc, ok_t);
    ex = sb.pop_front();
    total += 5;
    if (!(ok_s && ok_t)) begin bad++; $display("FAIL %s_timeout accepted=%b produced=%b want=1,1", name, ok_s, ok_t); end
    if (r !== ex.res)    begin bad++; $display("FAIL %s_result got=%h want=%h", name, r, ex.res); end
    if (z !== ex.zero)   begin bad++; $display("FAIL %s_zero got=%b want=%b", name, z, ex.zero); end
    if (e !== ex.err)    begin bad++; $display("FAIL %s_error got=%b want=%b", name, e, ex.err); end
    if (cyc !== lat)     begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, cyc, lat); end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops[6] = '{4'b0011, 4'b0100, 4'b0100, 4'b1001, 4'b0001, 4'b1111};
    logic [31:0] as[6]  = '{32'd5, 32'd3, 32'd0, 32'd5, 32'hF0, 32'h1234};
    logic [31:0] bs[6]  = '{32'd7, 32'd3, 32'd1, 32'd5, 32'h0F, 32'h1};
    for (int i = 0; i < 6; i++) test_ops($sformatf("single%0d", i), ops[i], as[i], bs[i], 5'd3);
  endtask

  task automatic test_shift();
    logic [3:0]  ops[5] = '{4'b0010, 4'b0101, 4'b0010, 4'b0010, 4'b0101};
    logic [31:0] as[5]  = '{32'h1, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'hF000_000F};
    logic [4:0]  shs[5] = '{5'd4, 5'd31, 5'd0, 5'd1, 5'd3};
    for (int i = 0; i < 5; i++) test_ops($sformatf("shift%0d", i), ops[i], as[i], 32'h55, shs[i]);
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic z, e; int cyc; bit ok_s, ok_t; exp_t ex;
    send(4'b0011, 32'd40, 32'd2, 5'd0, ok_s);
    ex = sb.pop_front();
    alu_operation = 4'b0001; a = 32'hA0; b = 32'h05; shamt = 5'd0; valid = 1'b1;
    sb.push_back(model(4'b0001, 32'hA0, 32'h05, 5'd0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++;
      if ({res_valid, ready, result, error} !== {1'b1, 1'b0, ex.res, 1'b0}) begin
        bad++;
        $display("FAIL stall%0d got valid=%b ready=%b result=%h want valid=1 ready=0 result=%h",
                 i, res_valid, ready, result, ex.res);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    total++;
    if ({ready, res_valid} !== 2'b10) begin bad++; $display("FAIL release_idle got ready=%b valid=%b want 1,0", ready, res_valid); end
    @(posedge clk); #1;
    valid = 1'b0;
    take(r, z, e, cyc, ok_t);
    ex = sb.pop_front();
    total += 3;
    if (!ok_s || !ok_t)  begin bad++; $display("FAIL bp_timeout got=%b%b want=11", ok_s, ok_t); end
    if (r !== ex.res)    begin bad++; $display("FAIL bp_pending_result got=%h want=%h", r, ex.res); end
    if (cyc !== 1)       begin bad++; $display("FAIL bp_pending_latency got=%0d want=1", cyc); end
  endtask

  task automatic test_reset_mid_shift();
    bit ok_s;
    send(4'b0010, 32'h3, 32'h0, 5'd20, ok_s);
    repeat (9) @(posedge clk);
    #1;
    total++;
    if ({ok_s, ready, res_valid} !== 3'b100) begin bad++; $display("FAIL midshift_busy got acc=%b ready=%b valid=%b want 1,0,0", ok_s, ready, res_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    total += 3;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", res_valid); end
    if (ready !== 1'b1)     begin bad++; $display("FAIL midreset_ready got=%b want=1", ready); end
    if (result !== 32'h0)   begin bad++; $display("FAIL midreset_result got=%h want=0", result); end
    test_ops("post_reset_add", 4'b0011, 32'd100, 32'd23, 5'd0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops[6] = '{4'b0011, 4'b0001, 4'b0100, 4'b0010, 4'b0101, 4'b0111};
    for (int i = 0; i < 8; i++)
      test_ops($sformatf("rand%0d", i), ops[$urandom_range(5)], $urandom, $urandom,
               5'($urandom_range(31)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; valid = 1'b0; res_ready = 1'b0;
    alu_operation = 4'h0; a = 32'h0; b = 32'h0; shamt = 5'd0;
    test_reset();
    test_single_cycle();
    test_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
